// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the 4-digit 7-segment bus slave.
//   - register byte offsets within the slave's 8-byte window
//   - CTRL bit positions
//   - 16-entry active-low hex segment table, bit order g..a
//   - handshake FSM state encoding
package seg_pkg;

  localparam logic [2:0] DATA_OFS = 3'd0;
  localparam logic [2:0] CTRL_OFS = 3'd4;

  localparam int CTRL_HSEL  = 0;
  localparam int CTRL_BLANK = 1;

  // Entry n is the active-low g..a pattern for hex digit n (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low 7-segment decoder.
//   i_nibble : 4-bit value to display
//   o_seg    : active-low segments, [6:0] = g..a
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_slave.sv
// seg_scan_slave: CPU bus responder driving a 4-digit multiplexed
// 7-segment display.
//   clk, rst   : system clock, synchronous active-high reset
//   bus_req    : request, held by master until bus_ack
//   bus_we     : 1 = write, 0 = read
//   bus_addr   : byte address; [31:3] must match BASE_ADDR, [2] selects
//                DATA (0) or CTRL (1)
//   bus_wdata  : write data
//   bus_rdata  : read data, non-zero only while bus_ack is high
//   bus_ack    : one-cycle completion pulse
//   seg        : active-low segments, [6:0] = g..a, [7] = dp
//   an         : active-low digit enables, [0] = rightmost digit
// Optional build macro SEG_DP_EN: lights dp on digit 0 while the high
// halfword is selected; without it dp is always off.
module seg_scan_slave
  import seg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_t           r_state;
  logic             r_ack;
  logic [31:0]      r_rdata;
  logic [31:0]      r_data;
  logic [1:0]       r_ctrl;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [7:0]       r_seg;
  logic [3:0]       r_an;

  logic        w_match;
  logic        w_sel_ctrl;
  logic [15:0] w_half;
  logic [3:0]  w_nibble;
  logic [6:0]  w_hex;
  logic        w_dp;
  logic        w_unused_addr;

  assign w_match       = (bus_addr[31:3] == BASE_ADDR[31:3]);
  assign w_sel_ctrl    = ((bus_addr[2:0] & 3'b100) == CTRL_OFS);
  assign w_unused_addr = &{1'b0, bus_addr[1:0]};

  // Handshake FSM plus register file. Access happens on the sampling edge
  // in IDLE; the following ACK cycle ignores bus_req so a held request is
  // not executed twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
      r_data  <= 32'd0;
      r_ctrl  <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack   <= 1'b0;
          r_rdata <= 32'd0;
          if (bus_req && w_match) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            if (bus_we) begin
              if (w_sel_ctrl) r_ctrl <= bus_wdata[1:0];
              else            r_data <= bus_wdata;
            end else begin
              r_rdata <= w_sel_ctrl ? {30'd0, r_ctrl} : r_data;
            end
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_rdata <= 32'd0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_rdata <= 32'd0;
        end
      endcase
    end
  end

  // Scan divider and digit index; both keep running while blanked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_half   = r_ctrl[CTRL_HSEL] ? r_data[31:16] : r_data[15:0];
  assign w_nibble = 4'(w_half >> {r_idx, 2'b00});

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_hex)
  );

`ifdef SEG_DP_EN
  assign w_dp = ~((r_idx == 2'd0) && r_ctrl[CTRL_HSEL]);
`else
  assign w_dp = 1'b1;
`endif

  // Display outputs are registered from the current index/data/ctrl, so a
  // DATA write and a digit advance on the same edge both appear together
  // one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 4'b1110;
      r_seg <= 8'hC0;
    end else if (r_ctrl[CTRL_BLANK]) begin
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= {w_dp, w_hex};
    end
  end

  assign bus_ack   = r_ack;
  assign bus_rdata = r_rdata;
  assign seg       = r_seg;
  assign an        = r_an;

endmodule
